// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: top-level sequencer for the 8x8 LED maze game.
// Owns the game state, current level, remaining lives and the result-screen
// hold counter; drives countdown reload/enable, player re-home/freeze and the
// map-bank select.
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   tick                  - one-cycle slow-clock strobe (pre-synchronised)
//   start                 - one-cycle validated start-key pulse
//   hit_wall, at_goal,
//   time_zero             - level conditions from collision/timer blocks
//   state                 - current FSM state code
//   level, lives          - current level index and remaining lives
//   screen                - map bank: 00 maze, 01 idle, 10 win, 11 lose
//   timer_load, timer_en  - countdown reload pulse and enable
//   player_rst,
//   player_freeze         - player re-home pulse and movement lock
//   game_won              - all levels cleared (meaningful in DONE)
module maze_game_ctrl #(
   parameter int unsigned NUM_LEVELS = 3,
   parameter int unsigned LIVES      = 3,
   parameter int unsigned SHOW_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       hit_wall,
   input  logic       at_goal,
   input  logic       time_zero,
   output logic [2:0] state,
   output logic [1:0] level,
   output logic [1:0] screen,
   output logic [1:0] lives,
   output logic       timer_load,
   output logic       timer_en,
   output logic       player_rst,
   output logic       player_freeze,
   output logic       game_won
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_PLAY = 3'd2;
   localparam logic [2:0] S_WIN  = 3'd4;
   localparam logic [2:0] S_LOSE = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [3:0] SHOW_LAST  = 4'(SHOW_TICKS - 1);

   logic [2:0] state_q, state_d;
   logic [1:0] level_q, level_d;
   logic [1:0] lives_q, lives_d;
   logic       won_q,   won_d;
   logic [3:0] cnt_q,   cnt_d;

   // State and game-data registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         level_q <= 2'd0;
         lives_q <= LIVES_INIT;
         won_q   <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         lives_q <= lives_d;
         won_q   <= won_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and game-data update
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      lives_d = lives_q;
      won_d   = won_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_PLAY;
         end
         S_PLAY: begin
            // A loss outranks reaching the goal on the same cycle
            if (hit_wall || time_zero) begin
               state_d = S_LOSE;
               cnt_d   = 4'd0;
               if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            end else if (at_goal) begin
               state_d = S_WIN;
               cnt_d   = 4'd0;
            end
         end
         S_WIN: begin
            if (tick) begin
               if (cnt_q == SHOW_LAST) begin
                  if (level_q >= LAST_LEVEL) begin
                     state_d = S_DONE;
                     won_d   = 1'b1;
                  end else begin
                     state_d = S_LOAD;
                     level_d = level_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_LOSE: begin
            if (tick) begin
               if (cnt_q == SHOW_LAST) begin
                  if (lives_q == 2'd0) begin
                     state_d = S_DONE;
                     won_d   = 1'b0;
                  end else begin
                     state_d = S_LOAD;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               level_d = 2'd0;
               lives_d = LIVES_INIT;
               won_d   = 1'b0;
            end
         end
         default: begin
            // Unused codes recover to IDLE
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore output decode from the state register
   always_comb begin
      screen        = 2'b01;
      timer_load    = 1'b0;
      timer_en      = 1'b0;
      player_rst    = 1'b0;
      player_freeze = 1'b1;
      case (state_q)
         S_LOAD: begin
            screen     = 2'b00;
            timer_load = 1'b1;
            player_rst = 1'b1;
         end
         S_PLAY: begin
            screen        = 2'b00;
            timer_en      = 1'b1;
            player_freeze = 1'b0;
         end
         S_WIN:   screen = 2'b10;
         S_LOSE:  screen = 2'b11;
         S_DONE:  screen = won_q ? 2'b10 : 2'b11;
         default: screen = 2'b01;
      endcase
   end

   assign state    = state_q;
   assign level    = level_q;
   assign lives    = lives_q;
   assign game_won = won_q;

endmodule
